// File: rtl/key_matrix_scan.sv
// key_matrix_scan
//   Scans and debounces a 4x4 matrix keypad. One row is driven low per slot.
//   The column lines are sampled at the end of each slot. The full 16-key map
//   is debounced over whole scans, and one press event and one release event
//   are reported.
// Ports
//   clk          system clock
//   rst_n        async active-low reset
//   col_in[3:0]  column lines, active low, asynchronous to clk
//   row_out[3:0] row drive, active low, exactly one bit low
//   key_valid    1-cycle pulse: press accepted, key_code valid
//   key_code     lowest pressed key index (row*4+col), held until next press
//   key_down     level: a reported key is still held
//   key_release  1-cycle pulse: all keys released after a report
//   key_map      debounced map, bit i = key i pressed
module key_matrix_scan #(
  parameter int SCAN_DIV       = 50_000,
  parameter int DEBOUNCE_SCANS = 20
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  col_in,
  output logic [3:0]  row_out,
  output logic        key_valid,
  output logic [3:0]  key_code,
  output logic        key_down,
  output logic        key_release,
  output logic [15:0] key_map
);

  localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int SW = (DEBOUNCE_SCANS > 0) ? $clog2(DEBOUNCE_SCANS + 1) : 1;
  localparam logic [CW-1:0] CNT_LAST   = CW'(SCAN_DIV - 1);
  localparam logic [SW-1:0] STABLE_MAX = SW'(DEBOUNCE_SCANS);

  typedef enum logic {IDLE, PRESSED} state_t;

  // --------------------------------------------------------------------
  // Column synchroniser
  // The flops reset to "all released" (lines pulled high).
  // --------------------------------------------------------------------
  logic [3:0] col_s1, col_s2;
  logic [3:0] cols;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_s1 <= 4'hF;
      col_s2 <= 4'hF;
    end else begin
      col_s1 <= col_in;
      col_s2 <= col_s1;
    end
  end

  assign cols = ~col_s2;

  // --------------------------------------------------------------------
  // Slot counter and row rotation
  // --------------------------------------------------------------------
  logic [CW-1:0] cnt;
  logic [1:0]    row;
  logic [1:0]    row_nxt;
  logic          slot_end;
  logic          scan_end;

  assign slot_end = (cnt == CNT_LAST);
  assign scan_end = slot_end && (row == 2'd3);
  assign row_nxt  = row + 2'd1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt     <= '0;
      row     <= 2'd0;
      row_out <= 4'b1110;
    end else begin
      if (slot_end) begin
        cnt     <= '0;
        row     <= row_nxt;
        row_out <= ~(4'b0001 << row_nxt);
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  // --------------------------------------------------------------------
  // Snapshot / debounce
  // snap_nxt is the snapshot including the columns being sampled now. At
  // scan end it is the complete scan, so the comparison uses it rather
  // than the stale register.
  // --------------------------------------------------------------------
  logic [15:0]   snapshot;
  logic [15:0]   snap_prev;
  logic [15:0]   snap_nxt;
  logic [SW-1:0] stable;
  logic [SW-1:0] stable_nxt;
  logic          accept;

  always_comb begin
    snap_nxt = snapshot;
    snap_nxt[{row, 2'b00} +: 4] = cols;
  end

  always_comb begin
    stable_nxt = '0;
    if (snap_nxt == snap_prev)
      stable_nxt = (stable == STABLE_MAX) ? STABLE_MAX : stable + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      snapshot  <= '0;
      snap_prev <= '0;
      stable    <= '0;
      accept    <= 1'b0;
      key_map   <= '0;
    end else begin
      accept <= 1'b0;
      if (slot_end)
        snapshot <= snap_nxt;
      if (scan_end) begin
        stable    <= stable_nxt;
        snap_prev <= snap_nxt;
        accept    <= (stable_nxt == STABLE_MAX);
      end
      // The snapshot is the full scan for SCAN_DIV cycles after scan end.
      // Row 0 is not rewritten before then, so it is safe to copy here.
      if (accept)
        key_map <= snapshot;
    end
  end

  // --------------------------------------------------------------------
  // Event FSM
  // --------------------------------------------------------------------
  function automatic logic [3:0] lowest_idx(input logic [15:0] m);
    logic [3:0] idx;
    idx = 4'd0;
    for (int i = 15; i >= 0; i--)
      if (m[i]) idx = 4'(i);
    return idx;
  endfunction

  state_t state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      key_valid   <= 1'b0;
      key_code    <= 4'd0;
      key_down    <= 1'b0;
      key_release <= 1'b0;
    end else begin
      key_valid   <= 1'b0;
      key_release <= 1'b0;
      case (state)
        IDLE: begin
          if (key_map != 16'd0) begin
            state     <= PRESSED;
            key_valid <= 1'b1;
            key_code  <= lowest_idx(key_map);
            key_down  <= 1'b1;
          end else begin
            key_down <= 1'b0;
          end
        end
        PRESSED: begin
          // key_down stays high through the release pulse and drops next cycle.
          if (key_map == 16'd0) begin
            state       <= IDLE;
            key_release <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_key_matrix_scan.sv
module tb_key_matrix_scan;

  logic        clk;
  logic        rst_n;
  logic [3:0]  col_in;
  logic [3:0]  row_out;
  logic        key_valid;
  logic [3:0]  key_code;
  logic        key_down;
  logic        key_release;
  logic [15:0] key_map;

  logic [15:0] keys;

  int total;
  int bad;
  int nv;
  int nr;
  int both_hi;
  int bad_row;

  key_matrix_scan #(.SCAN_DIV(4), .DEBOUNCE_SCANS(3)) dut (
    .clk(clk), .rst_n(rst_n), .col_in(col_in), .row_out(row_out),
    .key_valid(key_valid), .key_code(key_code), .key_down(key_down),
    .key_release(key_release), .key_map(key_map)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Keypad model: a held key pulls its column low while its row is driven.
  always_comb begin
    col_in = 4'hF;
    for (int r = 0; r < 4; r++)
      if (!row_out[r])
        for (int c = 0; c < 4; c++)
          if (keys[r*4+c]) col_in[c] = 1'b0;
  end

  // Event monitor: samples 2 ns after each rising edge.
  initial begin
    nv = 0; nr = 0; both_hi = 0; bad_row = 0;
    forever begin
      @(posedge clk);
      #2;
      if (key_valid) nv++;
      if (key_release) nr++;
      if (key_valid && key_release) both_hi++;
      if (!(row_out == 4'b1110 || row_out == 4'b1101 ||
            row_out == 4'b1011 || row_out == 4'b0111)) bad_row++;
    end
  end

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset(input logic [15:0] k);
    @(negedge clk);
    rst_n = 1'b0;
    keys  = k;
    wait_cyc(3);
    rst_n = 1'b1;
  endtask

  task automatic test_reset;
    logic [3:0] exp_row;
    int nv0;
    @(negedge clk);
    rst_n = 1'b0;
    keys  = 16'h0;
    wait_cyc(2);
    total++;
    if (row_out !== 4'b1110 || key_valid !== 1'b0 || key_code !== 4'd0 ||
        key_down !== 1'b0 || key_release !== 1'b0 || key_map !== 16'h0) begin
      bad++;
      $display("FAIL reset_state: row=%b v=%b code=%0d down=%b rel=%b map=%h, want row=1110 rest 0",
               row_out, key_valid, key_code, key_down, key_release, key_map);
    end
    nv0 = nv;
    rst_n = 1'b1;
    for (int k = 0; k < 32; k++) begin
      if (k > 0) @(negedge clk);
      exp_row = ~(4'b0001 << ((k / 4) % 4));
      total++;
      if (row_out !== exp_row) begin
        bad++;
        $display("FAIL row_rotate k=%0d: row_out=%b want %b", k, row_out, exp_row);
      end
    end
    wait_cyc(48);
    total++;
    if (nv !== nv0 || key_map !== 16'h0 || key_down !== 1'b0) begin
      bad++;
      $display("FAIL idle_no_event: valid_count=%0d map=%h down=%b want %0d 0000 0",
               nv - nv0, key_map, key_down, 0);
    end
  endtask

  task automatic test_single_press;
    int nv0;
    nv0 = nv;
    do_reset(16'h0040);
    wait_cyc(83);
    total++;
    if (nv - nv0 !== 1 || key_code !== 4'd6 || key_map !== 16'h0040 || key_down !== 1'b1) begin
      bad++;
      $display("FAIL single_press: valids=%0d code=%0d map=%h down=%b want 1 6 0040 1",
               nv - nv0, key_code, key_map, key_down);
    end
  endtask

  task automatic test_bounce;
    int nv0, nr0;
    nv0 = nv; nr0 = nr;
    do_reset(16'h0000);
    for (int i = 0; i < 16; i++) begin
      keys = (i % 2 == 0) ? 16'h0040 : 16'h0000;
      wait_cyc(5);
    end
    keys = 16'h0040;
    wait_cyc(130);
    total++;
    if (nv - nv0 !== 1 || key_code !== 4'd6 || key_map !== 16'h0040) begin
      bad++;
      $display("FAIL bounce_press: valids=%0d code=%0d map=%h want 1 6 0040",
               nv - nv0, key_code, key_map);
    end
    for (int i = 0; i < 16; i++) begin
      keys = (i % 2 == 0) ? 16'h0000 : 16'h0040;
      wait_cyc(5);
    end
    keys = 16'h0000;
    wait_cyc(130);
    total++;
    if (nr - nr0 !== 1 || nv - nv0 !== 1 || key_down !== 1'b0 || key_map !== 16'h0) begin
      bad++;
      $display("FAIL bounce_release: releases=%0d valids=%0d down=%b map=%h want 1 1 0 0000",
               nr - nr0, nv - nv0, key_down, key_map);
    end
  endtask

  task automatic test_multi_key;
    int nv0, nr0;
    nv0 = nv; nr0 = nr;
    do_reset(16'h0208);
    wait_cyc(100);
    total++;
    if (nv - nv0 !== 1 || key_code !== 4'd3 || key_map !== 16'h0208 || key_down !== 1'b1) begin
      bad++;
      $display("FAIL multi_press: valids=%0d code=%0d map=%h down=%b want 1 3 0208 1",
               nv - nv0, key_code, key_map, key_down);
    end
    keys = 16'h0200;
    wait_cyc(100);
    total++;
    if (nv - nv0 !== 1 || nr - nr0 !== 0 || key_map !== 16'h0200 || key_down !== 1'b1) begin
      bad++;
      $display("FAIL multi_partial_release: valids=%0d rels=%0d map=%h down=%b want 1 0 0200 1",
               nv - nv0, nr - nr0, key_map, key_down);
    end
    keys = 16'h0000;
    wait_cyc(100);
    total++;
    if (nr - nr0 !== 1 || key_down !== 1'b0 || key_map !== 16'h0 || key_code !== 4'd3) begin
      bad++;
      $display("FAIL multi_release: rels=%0d down=%b map=%h code=%0d want 1 0 0000 3",
               nr - nr0, key_down, key_map, key_code);
    end
  endtask

  task automatic test_glitch;
    int nv0;
    bit found;
    nv0 = nv;
    do_reset(16'h0000);
    found = 0;
    for (int i = 0; i < 64 && !found; i++) begin
      @(negedge clk);
      if (row_out == 4'b0111) found = 1;
    end
    total++;
    if (!found) begin
      bad++;
      $display("FAIL glitch_row3_timeout: row_out=%b want 0111 within 64 cycles", row_out);
    end
    // Row 3 slot now at count 0; press during counts 2 and 3, after the sampled window.
    wait_cyc(2);
    keys = 16'h1000;
    wait_cyc(2);
    keys = 16'h0000;
    wait_cyc(100);
    total++;
    if (nv - nv0 !== 0 || key_map !== 16'h0) begin
      bad++;
      $display("FAIL glitch_ignored: valids=%0d map=%h want 0 0000", nv - nv0, key_map);
    end
  endtask

  task automatic test_reset_midpress;
    int nv0;
    nv0 = nv;
    do_reset(16'h0020);
    wait_cyc(100);
    total++;
    if (nv - nv0 !== 1 || key_code !== 4'd5 || key_down !== 1'b1) begin
      bad++;
      $display("FAIL midpress_first: valids=%0d code=%0d down=%b want 1 5 1",
               nv - nv0, key_code, key_down);
    end
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    total++;
    if (row_out !== 4'b1110 || key_valid !== 1'b0 || key_code !== 4'd0 ||
        key_down !== 1'b0 || key_release !== 1'b0 || key_map !== 16'h0) begin
      bad++;
      $display("FAIL midpress_async_reset: row=%b v=%b code=%0d down=%b rel=%b map=%h want 1110 0 0 0 0 0000",
               row_out, key_valid, key_code, key_down, key_release, key_map);
    end
    wait_cyc(3);
    nv0 = nv;
    rst_n = 1'b1;
    wait_cyc(100);
    total++;
    if (nv - nv0 !== 1 || key_code !== 4'd5 || key_map !== 16'h0020 || key_down !== 1'b1) begin
      bad++;
      $display("FAIL midpress_again: valids=%0d code=%0d map=%h down=%b want 1 5 0020 1",
               nv - nv0, key_code, key_map, key_down);
    end
    keys = 16'h0000;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    keys  = 16'h0;
    test_reset();
    test_single_press();
    test_bounce();
    test_multi_key();
    test_glitch();
    test_reset_midpress();
    total++;
    if (both_hi !== 0 || bad_row !== 0) begin
      bad++;
      $display("FAIL invariants: valid_and_release=%0d bad_row_cycles=%0d want 0 0",
               both_hi, bad_row);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
